// File: rtl/alu_pkg.sv
// Shared definitions for the execute-stage ALU: op codes, FSM states, shift width.
package alu_pkg;

   // Operation codes, identical to the encoding produced by the ALU controller.
   localparam logic [3:0] OP_AND = 4'b0000;
   localparam logic [3:0] OP_OR  = 4'b0001;
   localparam logic [3:0] OP_ADD = 4'b0010;
   localparam logic [3:0] OP_SLL = 4'b0011;
   localparam logic [3:0] OP_XOR = 4'b0100;
   localparam logic [3:0] OP_SRL = 4'b0101;
   localparam logic [3:0] OP_SUB = 4'b0110;
   localparam logic [3:0] OP_EQ  = 4'b1000;
   localparam logic [3:0] OP_SRA = 4'b1010;
   localparam logic [3:0] OP_SLT = 4'b1100;

   // Default datapath width and the matching shift-amount width.
   localparam int DATA_WIDTH = 32;
   localparam int SHAMT_W    = $clog2(DATA_WIDTH);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   // Shifts go through the iterative shifter; everything else is single-cycle.
   function automatic logic is_shift(input logic [3:0] op);
      return (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA);
   endfunction

endpackage

// File: rtl/alu_comb_core.sv
// Single-cycle ALU evaluation: logic, add/sub, equality and signed less-than.
// Shift codes and undefined codes evaluate to 0 here.
module alu_comb_core
   import alu_pkg::*;
#(
   parameter int DATA_WIDTH = 32
) (
   input  logic [3:0]            op,
   input  logic [DATA_WIDTH-1:0] a,
   input  logic [DATA_WIDTH-1:0] b,
   output logic [DATA_WIDTH-1:0] result
);

   // Pure decode of the op code onto the matching arithmetic/logic result.
   always_comb begin
      result = '0;
      case (op)
         OP_AND: result = a & b;
         OP_OR:  result = a | b;
         OP_ADD: result = a + b;
         OP_XOR: result = a ^ b;
         OP_SUB: result = a - b;
         OP_EQ:  result = {{(DATA_WIDTH-1){1'b0}}, (a == b)};
         OP_SLT: result = {{(DATA_WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
         default: result = '0;
      endcase
   end

endmodule

// File: rtl/alu_exec_unit.sv
// Execute-stage ALU with valid/ready on both sides. Non-shift ops finish in one
// cycle; shifts step one bit per cycle through a shift register.
module alu_exec_unit
   import alu_pkg::*;
#(
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [3:0]            Operation,
   input  logic [DATA_WIDTH-1:0] SrcA,
   input  logic [DATA_WIDTH-1:0] SrcB,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] ALUResult,
   output logic                  Zero
);

   localparam int SHAMT_BITS = $clog2(DATA_WIDTH);

   state_t                  state_reg, state_next;
   logic [DATA_WIDTH-1:0]   shreg_reg;
   logic [DATA_WIDTH-1:0]   shift_next;
   logic [SHAMT_BITS-1:0]   cnt_reg;
   logic [3:0]              op_reg;
   logic [DATA_WIDTH-1:0]   result_reg;
   logic [DATA_WIDTH-1:0]   core_result;
   logic [SHAMT_BITS-1:0]   shamt;
   logic                    accept;
   logic                    req_shift;

   assign shamt     = SrcB[SHAMT_BITS-1:0];
   assign accept    = in_valid && (state_reg == IDLE);
   assign req_shift = is_shift(Operation);

   alu_comb_core #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_core (
      .op     (Operation),
      .a      (SrcA),
      .b      (SrcB),
      .result (core_result)
   );

   // One-bit step of the shift register in the direction of the captured op.
   always_comb begin
      shift_next = {1'b0, shreg_reg[DATA_WIDTH-1:1]};
      case (op_reg)
         OP_SLL:  shift_next = {shreg_reg[DATA_WIDTH-2:0], 1'b0};
         OP_SRA:  shift_next = {shreg_reg[DATA_WIDTH-1], shreg_reg[DATA_WIDTH-1:1]};
         default: shift_next = {1'b0, shreg_reg[DATA_WIDTH-1:1]};
      endcase
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_reg <= IDLE;
      else        state_reg <= state_next;
   end

   // Next-state logic: shamt=0 shifts skip straight to DONE like any single-cycle op.
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE: begin
            if (accept) begin
               if (req_shift && (shamt != '0)) state_next = SHIFT;
               else                            state_next = DONE;
            end
         end
         SHIFT: begin
            if (cnt_reg == SHAMT_BITS'(1)) state_next = DONE;
         end
         DONE: begin
            if (out_ready) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // Handshake outputs decoded from the state; Zero follows the registered result.
   always_comb begin
      in_ready  = (state_reg == IDLE);
      out_valid = (state_reg == DONE);
      ALUResult = result_reg;
      Zero      = (result_reg == '0);
   end

   // Datapath: capture on accept, iterate shifts, hold the result through DONE.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shreg_reg  <= '0;
         cnt_reg    <= '0;
         op_reg     <= OP_AND;
         result_reg <= '0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (accept) begin
                  if (req_shift) begin
                     if (shamt == '0) begin
                        result_reg <= SrcA;
                     end else begin
                        shreg_reg <= SrcA;
                        cnt_reg   <= shamt;
                        op_reg    <= Operation;
                     end
                  end else begin
                     result_reg <= core_result;
                  end
               end
            end
            SHIFT: begin
               shreg_reg <= shift_next;
               cnt_reg   <= cnt_reg - SHAMT_BITS'(1);
               if (cnt_reg == SHAMT_BITS'(1)) result_reg <= shift_next;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed plus random checks of alu_exec_unit against a plain-arithmetic model.
module tb_alu_exec_unit;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [3:0]  Operation;
   logic [31:0] SrcA;
   logic [31:0] SrcB;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] ALUResult;
   logic        Zero;

   int n_asserts = 0;
   int n_fail    = 0;

   alu_exec_unit #(.DATA_WIDTH(32)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .Operation (Operation),
      .SrcA      (SrcA),
      .SrcB      (SrcB),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .ALUResult (ALUResult),
      .Zero      (Zero)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference: result straight from the op-code table.
   function automatic logic [31:0] ref_result(input logic [3:0] op, input logic [31:0] a,
                                              input logic [31:0] b);
      int sh;
      sh = int'(b[4:0]);
      case (op)
         4'b0000: return a & b;
         4'b0001: return a | b;
         4'b0010: return a + b;
         4'b0011: return a << sh;
         4'b0100: return a ^ b;
         4'b0101: return a >> sh;
         4'b0110: return a - b;
         4'b1000: return (a == b) ? 32'd1 : 32'd0;
         4'b1010: return $unsigned($signed(a) >>> sh);
         4'b1100: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         default: return 32'd0;
      endcase
   endfunction

   // Reference: cycles from accept edge to first cycle with out_valid.
   function automatic int ref_latency(input logic [3:0] op, input logic [31:0] b);
      if ((op == 4'b0011 || op == 4'b0101 || op == 4'b1010) && b[4:0] != 5'd0)
         return int'(b[4:0]) + 1;
      return 1;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_asserts++;
      assert (obs === exp) else begin
         n_fail++;
         $display("FAIL %s: observed %h expected %h", tag, obs, exp);
         $error("check %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // One full transaction: accept, wait for result, optional backpressure, drain.
   task automatic run_op(input string name, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, input int stall);
      logic [31:0] exp;
      int          exp_lat;
      int          lat;
      exp     = ref_result(op, a, b);
      exp_lat = ref_latency(op, b);
      @(negedge clk);
      check({name, ".in_ready_idle"}, 32'(in_ready), 32'd1);
      in_valid  = 1'b1;
      Operation = op;
      SrcA      = a;
      SrcB      = b;
      @(posedge clk);
      #1;
      // Keep in_valid high with junk operands: must be ignored while busy.
      SrcA      = $urandom;
      SrcB      = $urandom;
      Operation = 4'($urandom);
      lat = 0;
      while (lat < 100) begin
         @(negedge clk);
         lat++;
         if (out_valid) break;
         check({name, ".in_ready_busy"}, 32'(in_ready), 32'd0);
      end
      in_valid = 1'b0;
      check({name, ".latency"}, 32'(lat), 32'(exp_lat));
      check({name, ".result"}, ALUResult, exp);
      check({name, ".zero"}, 32'(Zero), 32'(exp == 32'd0));
      check({name, ".in_ready_done"}, 32'(in_ready), 32'd0);
      for (int i = 0; i < stall; i++) begin
         @(negedge clk);
         check({name, ".held_valid"}, 32'(out_valid), 32'd1);
         check({name, ".held_result"}, ALUResult, exp);
      end
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      check({name, ".drain_valid"}, 32'(out_valid), 32'd0);
      check({name, ".drain_ready"}, 32'(in_ready), 32'd1);
      $display("txn %-8s op=%b a=%h b=%h -> %h lat=%0d stall=%0d", name, op, a, b,
               ALUResult, lat, stall);
   endtask

   // Hard stop in case something wedges the sequence.
   initial begin
      #2000000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [3:0] codes [13];
      logic [3:0] op;
      logic [31:0] a, b;
      int seen;
      codes = '{4'b0000, 4'b0001, 4'b0010, 4'b0011, 4'b0100, 4'b0101, 4'b0110,
                4'b1000, 4'b1010, 4'b1100, 4'b0111, 4'b1001, 4'b1111};

      rst_n     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      Operation = 4'd0;
      SrcA      = 32'd0;
      SrcB      = 32'd0;
      #1;
      check("reset.in_ready", 32'(in_ready), 32'd1);
      check("reset.out_valid", 32'(out_valid), 32'd0);
      check("reset.result", ALUResult, 32'd0);
      check("reset.zero", 32'(Zero), 32'd1);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      run_op("add", 4'b0010, 32'd5, 32'd7, 0);
      run_op("sub", 4'b0110, 32'h10, 32'h10, 0);
      run_op("slt", 4'b1100, 32'hFFFF_FFFF, 32'd1, 0);
      run_op("eq", 4'b1000, 32'hA, 32'hB, 0);
      run_op("sra4", 4'b1010, 32'h8000_0000, 32'd4, 0);
      run_op("sll0", 4'b0011, 32'd1, 32'd0, 0);
      run_op("srl31", 4'b0101, 32'hFFFF_FFFF, 32'd31, 3);

      // Reset in the middle of a 20-step shift.
      @(negedge clk);
      in_valid  = 1'b1;
      Operation = 4'b0101;
      SrcA      = 32'hFFFF_0000;
      SrcB      = 32'd20;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      repeat (5) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check("midrst.in_ready", 32'(in_ready), 32'd1);
      check("midrst.out_valid", 32'(out_valid), 32'd0);
      check("midrst.result", ALUResult, 32'd0);
      check("midrst.zero", 32'(Zero), 32'd1);
      @(negedge clk);
      rst_n = 1'b1;
      seen = 0;
      repeat (30) begin
         @(negedge clk);
         if (out_valid) seen++;
      end
      check("midrst.no_emit", 32'(seen), 32'd0);
      $display("txn midrst   srl by 20 interrupted, out_valid seen %0d times", seen);

      run_op("add11", 4'b0010, 32'd1, 32'd1, 0);
      run_op("undef", 4'b0111, 32'd3, 32'd4, 0);

      for (int i = 0; i < 40; i++) begin
         op = codes[$urandom_range(0, 12)];
         a  = $urandom;
         b  = $urandom;
         if ($urandom_range(0, 3) == 0) b = a;
         run_op("rand", op, a, b, int'($urandom_range(0, 2)));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
      $finish;
   end

endmodule

// File: doc/alu_exec_unit.md
# alu_exec_unit

- Execute-stage ALU.
- Directly downstream of the ALU controller: consumes the 4-bit `Operation` code together with the two operands and produces a registered result plus a zero flag.
- Single-cycle operations complete in one cycle. Shifts run on an iterative 1-bit-per-cycle shifter to save area.
- A valid/ready handshake on both sides lets the pipeline stall on multi-cycle shifts.

## Interface

- `DATA_WIDTH`, default 32: operand and result width. Shift amount is the low log2(`DATA_WIDTH`) bits of `SrcB`.
- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `in_valid`  in  1  request present.
- `in_ready`  out  1  unit can accept a request.
- `Operation`  in  4  ALU operation code from the ALU controller.
- `SrcA`  in  DATA_WIDTH  first operand.
- `SrcB`  in  DATA_WIDTH  second operand or shift amount.
- `out_valid`  out  1  result available.
- `out_ready`  in  1  consumer takes the result.
- `ALUResult`  out  DATA_WIDTH  registered result.
- `Zero`  out  1  high when `ALUResult` == 0.

## Operation

- **Op codes.** Only these values are defined; any other code yields result 0.
  - 0000 AND.
  - 0001 OR.
  - 0010 ADD.
  - 0011 SLL.
  - 0100 XOR.
  - 0101 SRL.
  - 0110 SUB.
  - 1000 EQ: result 1 if `SrcA`==`SrcB`, else 0.
  - 1010 SRA.
  - 1100 SLT: signed compare, result 1/0.
- **Arithmetic.** ADD/SUB wrap modulo 2^`DATA_WIDTH`, with no overflow flag. SRA replicates `SrcA` MSB.
- **Accept.** A request is accepted on a rising edge where `in_valid` && `in_ready`. Operands and op are captured at that edge; later input changes are ignored.
- **FSM states:** IDLE, SHIFT, DONE.
- **From IDLE:**
  - `in_ready`=1.
  - On accept of a non-shift op: result registered, go to DONE.
  - On accept of a shift with shamt=0: result=`SrcA`, go to DONE.
  - On accept of a shift with shamt>0: load `SrcA` into the shift register, counter=shamt, go to SHIFT.
- **SHIFT:**
  - Each cycle, shift by 1 in the op direction and decrement the counter.
  - When the counter goes 1→0, go to DONE.
  - `in_ready`=0.
- **DONE:**
  - `out_valid`=1.
  - `ALUResult` and `Zero` are held stable until `out_ready`=1 at an edge, then go to IDLE.
  - `in_ready`=0. There is no accept in the same cycle as the output handshake.
- `Zero` is derived from the registered result and is valid whenever `out_valid`=1.

## Timing

- **Reset values** (immediate on `rst_n` falling, independent of `clk`): state IDLE, `in_ready`=1, `out_valid`=0, `ALUResult`=0, `Zero`=1, counter=0.
- **Non-shift latency.** Accept at edge E0 → `out_valid` high in the cycle after E0 (latency 1).
- **Shift latency.** Shift by n≥1 accepted at E0 → `out_valid` high after edge E0+n (latency n+1). Shamt=0 gives latency 1.
- **Throughput.** Non-shift: one result per 2 cycles with `out_ready` held high.
- **Backpressure.** `out_ready` low in DONE holds the state indefinitely, with no result change.
- **Reset during SHIFT or DONE.** The operation is discarded and nothing is emitted after reset release.
- `in_valid` while `in_ready`=0 is ignored. The request must be held by the producer.

## Structure

- **Shared package `alu_pkg`:**
  - localparams for the ten op codes, shared with the ALU controller.
  - state enum (IDLE/SHIFT/DONE).
  - `SHAMT_W` = $clog2(`DATA_WIDTH`).
- **Sub-module `alu_comb_core`:** purely combinational AND/OR/ADD/SUB/XOR/EQ/SLT/default-0 evaluation.
- **Top level:** FSM, shift register, counter and output registers.

## Test plan

1. Reset then ADD 5+7 → `out_valid` one cycle after accept, `ALUResult`=12, `Zero`=0.
2. SUB 0x10−0x10 → `ALUResult`=0, `Zero`=1. SLT −1 vs 1 → 1. EQ 0xA vs 0xB → 0.
3. SRA 0x80000000 by 4 → `in_ready` low 4 cycles, `out_valid` 5 cycles after accept, `ALUResult`=0xF8000000. SLL 1 by 0 → 1 after latency 1.
4. SRL 0xFFFFFFFF by 31 with `out_ready`=0 for 3 cycles after `out_valid` → result 0x00000001 held stable, IDLE only after `out_ready`.
5. Assert `rst_n` low mid-SHIFT (shift by 20, after 5 cycles) → all outputs at reset values immediately, no `out_valid` after release. Then ADD 1+1 → 2.
6. Undefined op 0111 with `SrcA`=3, `SrcB`=4 → `ALUResult`=0, `Zero`=1.
